// File: rtl/control_sequencer.sv
// +----------------------------------------------------------------------------+
// | Module   : control_sequencer                                               |
// | Purpose  : Fetch/decode/execute sequencer driving one-hot datapath strobes  |
// |            for the 8-bit CPU core, with programmable RAM read latency.     |
// | Options  : define STEP_MODE_EN to pause after every retired instruction.   |
// | Revision : 1.0 - initial release                                           |
// +----------------------------------------------------------------------------+
`default_nettype none

module control_sequencer #(
    parameter int WAIT_CYCLES = 1,
    parameter int CNT_W       = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             run,
    input  logic             step,
    input  logic [3:0]       ir_opcode,
    output logic             pc_out,
    output logic             pc_inc,
    output logic             pc_load,
    output logic             ir_addr_out,
    output logic             mar_load,
    output logic             ram_rd,
    output logic             ir_load,
    output logic             a_load,
    output logic             b_load,
    output logic [1:0]       alu_op,
    output logic             alu_en,
    output logic             halted,
    output logic             illegal_op,
    output logic [CNT_W-1:0] instr_count
);

    localparam logic [3:0] c_OP_LDA = 4'b1000;
    localparam logic [3:0] c_OP_LDB = 4'b0100;
    localparam logic [3:0] c_OP_ADD = 4'b0010;
    localparam logic [3:0] c_OP_SUB = 4'b0001;
    localparam logic [3:0] c_OP_MUL = 4'b1100;
    localparam logic [3:0] c_OP_DIV = 4'b1010;
    localparam logic [3:0] c_OP_JMP = 4'b1001;
    localparam logic [3:0] c_OP_HLT = 4'b1111;

    localparam logic [1:0] c_WAIT_LAST = 2'(WAIT_CYCLES - 1);

    typedef enum logic [3:0] {
        S_IDLE   = 4'd0,
        S_F_ADDR = 4'd1,
        S_F_WAIT = 4'd2,
        S_F_IR   = 4'd3,
        S_DECODE = 4'd4,
        S_X_ADDR = 4'd5,
        S_X_WAIT = 4'd6,
        S_X_DO   = 4'd7,
        S_HALT   = 4'd8
`ifdef STEP_MODE_EN
        ,
        S_PAUSE  = 4'd9
`endif
    } state_t;

`ifdef STEP_MODE_EN
    localparam state_t c_RETIRE_NEXT = S_PAUSE;
`else
    localparam state_t c_RETIRE_NEXT = S_F_ADDR;
    logic w_unused_step;
    assign w_unused_step = step;
`endif

    state_t           state_q;
    logic [3:0]       op_q;
    logic [1:0]       wait_q;
    logic             illegal_q;
    logic [CNT_W-1:0] cnt_q;

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= S_IDLE;
            op_q      <= 4'd0;
            wait_q    <= 2'd0;
            illegal_q <= 1'b0;
            cnt_q     <= '0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    if (run) begin
                        state_q <= S_F_ADDR;
                    end
                end
                S_F_ADDR: begin
                    wait_q  <= 2'd0;
                    state_q <= S_F_WAIT;
                end
                S_F_WAIT: begin
                    if (wait_q == c_WAIT_LAST) begin
                        state_q <= S_F_IR;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_F_IR: begin
                    state_q <= S_DECODE;
                end
                S_DECODE: begin
                    op_q <= ir_opcode;
                    case (ir_opcode)
                        c_OP_LDA, c_OP_LDB, c_OP_ADD,
                        c_OP_SUB, c_OP_MUL, c_OP_DIV: state_q <= S_X_ADDR;
                        c_OP_JMP: state_q <= S_X_DO;
                        c_OP_HLT: begin
                            cnt_q   <= cnt_q + 1'b1;
                            state_q <= S_HALT;
                        end
                        default: begin
                            // Undefined opcodes retire immediately and flag the fault.
                            illegal_q <= 1'b1;
                            cnt_q     <= cnt_q + 1'b1;
                            state_q   <= c_RETIRE_NEXT;
                        end
                    endcase
                end
                S_X_ADDR: begin
                    wait_q  <= 2'd0;
                    state_q <= S_X_WAIT;
                end
                S_X_WAIT: begin
                    if (wait_q == c_WAIT_LAST) begin
                        state_q <= S_X_DO;
                    end else begin
                        wait_q <= wait_q + 2'd1;
                    end
                end
                S_X_DO: begin
                    cnt_q   <= cnt_q + 1'b1;
                    state_q <= c_RETIRE_NEXT;
                end
                S_HALT: begin
                    state_q <= S_HALT;
                end
`ifdef STEP_MODE_EN
                S_PAUSE: begin
                    if (step) begin
                        state_q <= S_F_ADDR;
                    end
                end
`endif
                default: begin
                    state_q <= S_IDLE;
                end
            endcase
        end
    end

    // Strobes are pure decodes of the state and latched opcode, so a reset
    // drops them on the very next cycle.
    always_comb begin
        pc_out      = 1'b0;
        pc_inc      = 1'b0;
        pc_load     = 1'b0;
        ir_addr_out = 1'b0;
        mar_load    = 1'b0;
        ram_rd      = 1'b0;
        ir_load     = 1'b0;
        a_load      = 1'b0;
        b_load      = 1'b0;
        alu_op      = 2'b00;
        alu_en      = 1'b0;
        halted      = 1'b0;
        case (state_q)
            S_F_ADDR: begin
                pc_out   = 1'b1;
                mar_load = 1'b1;
            end
            S_F_WAIT: ram_rd = 1'b1;
            S_F_IR: begin
                ir_load = 1'b1;
                pc_inc  = 1'b1;
            end
            S_X_ADDR: begin
                ir_addr_out = 1'b1;
                mar_load    = 1'b1;
            end
            S_X_WAIT: ram_rd = 1'b1;
            S_X_DO: begin
                case (op_q)
                    c_OP_LDA: a_load = 1'b1;
                    c_OP_LDB: b_load = 1'b1;
                    c_OP_ADD: begin
                        alu_en = 1'b1;
                        b_load = 1'b1;
                        alu_op = 2'b00;
                    end
                    c_OP_SUB: begin
                        alu_en = 1'b1;
                        b_load = 1'b1;
                        alu_op = 2'b01;
                    end
                    c_OP_MUL: begin
                        alu_en = 1'b1;
                        b_load = 1'b1;
                        alu_op = 2'b10;
                    end
                    c_OP_DIV: begin
                        alu_en = 1'b1;
                        b_load = 1'b1;
                        alu_op = 2'b11;
                    end
                    c_OP_JMP: begin
                        ir_addr_out = 1'b1;
                        pc_load     = 1'b1;
                    end
                    default: ;
                endcase
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

    assign illegal_op  = illegal_q;
    assign instr_count = cnt_q;

endmodule

`default_nettype wire
